// File: rtl/dev_uart.sv
// Memory-mapped 8N1 UART: TX/RX FIFOs, programmable bit period, level interrupts.
// One transaction per stb; ack and dtr are registered one cycle later.
module dev_uart #(
    parameter int unsigned FIFO_AW  = 3,
    parameter int unsigned DIV_BITS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stb,
    output logic        ack,
    input  logic [9:0]  addr,
    input  logic        rw,
    input  logic [31:0] dtw,
    output logic [31:0] dtr,
    input  logic        rx,
    output logic        tx,
    output logic        int_rx,
    output logic        int_tx
);
    localparam int unsigned Depth = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] CntFull = (FIFO_AW+1)'(Depth);
    localparam logic [FIFO_AW:0] CntOne = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PtrOne = FIFO_AW'(1);

    typedef enum logic [1:0] {TxIdle, TxStart, TxData, TxStop} tx_state_e;
    typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

    logic                ack_q, ack_d, ovr_q, ovr_d, ferr_q, ferr_d, tx_q, tx_d;
    logic                int_rx_q, int_rx_d, int_tx_q, int_tx_d;
    logic [31:0]         dtr_q, dtr_d, rdata, rx_cnt_ext, tx_cnt_ext;
    logic [DIV_BITS-1:0] div_q, div_d, bit_max, half_max, tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic [DIV_BITS:0]   period;
    logic [3:0]          ctrl_q, ctrl_d;
    logic [7:0]          txf_mem_q [Depth];
    logic [7:0]          rxf_mem_q [Depth];
    logic [FIFO_AW-1:0]  txf_wp_q, txf_rp_q, rxf_wp_q, rxf_rp_q;
    logic [FIFO_AW:0]    txf_cnt_q, txf_cnt_d, rxf_cnt_q, rxf_cnt_d;
    tx_state_e           tx_state_q, tx_state_d;
    rx_state_e           rx_state_q, rx_state_d;
    logic [7:0]          tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic [2:0]          tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic                acc, wr_en, rd_en, txf_empty, txf_full, rxf_empty, rxf_full;
    logic                tx_pop, txf_push, rxf_pop, rxf_push, rx_stop_ok, rx_stop_bad;
    logic                set_ovr, tx_tick, rx_tick, unused_dtw;

    assign acc = stb & ~ack_q;
    assign wr_en = acc & rw;
    assign rd_en = acc & ~rw;
    assign unused_dtw = ^dtw[31:DIV_BITS];

    // Timers load bit_max so a state lasts bit_max+1 clocks; DIV changes land at the next load.
    assign bit_max = (div_q < DIV_BITS'(3)) ? DIV_BITS'(3) : div_q;
    assign period = {1'b0, bit_max} + (DIV_BITS+1)'(1);
    assign half_max = DIV_BITS'((period >> 1) - (DIV_BITS+1)'(1));

    assign txf_empty = (txf_cnt_q == '0);
    assign txf_full = (txf_cnt_q == CntFull);
    assign rxf_empty = (rxf_cnt_q == '0);
    assign rxf_full = (rxf_cnt_q == CntFull);

    // A pop in the same cycle frees the slot, so a push into a full FIFO still succeeds.
    assign txf_push = wr_en & (addr == 10'd0) & (~txf_full | tx_pop);
    assign rxf_pop = rd_en & (addr == 10'd0) & ~rxf_empty;
    assign rxf_push = rx_stop_ok & (~rxf_full | rxf_pop);
    assign set_ovr = rx_stop_ok & rxf_full & ~rxf_pop;

    assign tx_tick = (tx_cnt_q == '0);
    assign rx_tick = (rx_cnt_q == '0);
    assign rx_cnt_ext = 32'(rxf_cnt_q);
    assign tx_cnt_ext = 32'(txf_cnt_q);

    always_comb begin
        rdata = '0;
        case (addr)
            10'd0: if (!rxf_empty) rdata = {23'b0, 1'b1, rxf_mem_q[rxf_rp_q]};
            10'd1: begin
                rdata[0] = txf_full;
                rdata[1] = txf_empty;
                rdata[2] = ~rxf_empty;
                rdata[3] = rxf_full;
                rdata[4] = ovr_q;
                rdata[5] = ferr_q;
                rdata[6] = (tx_state_q != TxIdle);
                rdata[11:8] = rx_cnt_ext[3:0];
                rdata[15:12] = tx_cnt_ext[3:0];
            end
            10'd2: rdata = 32'(div_q);
            10'd3: rdata = {28'b0, ctrl_q};
            default: rdata = '0;
        endcase
    end

    always_comb begin
        ack_d = acc;
        dtr_d = rd_en ? rdata : '0;
        div_d = (wr_en && addr == 10'd2) ? dtw[DIV_BITS-1:0] : div_q;
        ctrl_d = (wr_en && addr == 10'd3) ? dtw[3:0] : ctrl_q;
        ovr_d = (ovr_q & ~(wr_en && addr == 10'd1 && dtw[4])) | set_ovr;
        ferr_d = (ferr_q & ~(wr_en && addr == 10'd1 && dtw[5])) | rx_stop_bad;
        int_rx_d = ctrl_q[2] & ~rxf_empty;
        int_tx_d = ctrl_q[3] & txf_empty & (tx_state_q == TxIdle);
        txf_cnt_d = txf_cnt_q;
        if (txf_push && !tx_pop) txf_cnt_d = txf_cnt_q + CntOne;
        else if (!txf_push && tx_pop) txf_cnt_d = txf_cnt_q - CntOne;
        rxf_cnt_d = rxf_cnt_q;
        if (rxf_push && !rxf_pop) rxf_cnt_d = rxf_cnt_q + CntOne;
        else if (!rxf_push && rxf_pop) rxf_cnt_d = rxf_cnt_q - CntOne;
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d = tx_cnt_q;
        tx_sh_d = tx_sh_q;
        tx_bit_d = tx_bit_q;
        tx_d = tx_q;
        tx_pop = 1'b0;
        if (tx_state_q != TxIdle && !tx_tick) tx_cnt_d = tx_cnt_q - DIV_BITS'(1);
        case (tx_state_q)
            TxIdle, TxStop: begin
                if (tx_state_q == TxIdle || tx_tick) begin
                    if (ctrl_q[0] && !txf_empty) begin
                        tx_pop = 1'b1;
                        tx_sh_d = txf_mem_q[txf_rp_q];
                        tx_cnt_d = bit_max;
                        tx_d = 1'b0;
                        tx_state_d = TxStart;
                    end else begin
                        tx_state_d = TxIdle;
                    end
                end
            end
            TxStart: if (tx_tick) begin
                tx_state_d = TxData;
                tx_cnt_d = bit_max;
                tx_bit_d = '0;
                tx_d = tx_sh_q[0];
            end
            TxData: if (tx_tick) begin
                tx_cnt_d = bit_max;
                if (tx_bit_q == 3'd7) begin
                    tx_state_d = TxStop;
                    tx_d = 1'b1;
                end else begin
                    tx_sh_d = {1'b0, tx_sh_q[7:1]};
                    tx_d = tx_sh_q[1];
                    tx_bit_d = tx_bit_q + 3'd1;
                end
            end
            default: tx_state_d = TxIdle;
        endcase
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d = rx_cnt_q;
        rx_sh_d = rx_sh_q;
        rx_bit_d = rx_bit_q;
        rx_stop_ok = 1'b0;
        rx_stop_bad = 1'b0;
        if (rx_state_q != RxIdle && !rx_tick) rx_cnt_d = rx_cnt_q - DIV_BITS'(1);
        case (rx_state_q)
            RxIdle: if (ctrl_q[1] && !rx) begin
                rx_state_d = RxStart;
                rx_cnt_d = half_max;
            end
            RxStart: if (rx_tick) begin
                rx_state_d = rx ? RxIdle : RxData;
                rx_cnt_d = bit_max;
                rx_bit_d = '0;
            end
            RxData: if (rx_tick) begin
                rx_sh_d = {rx, rx_sh_q[7:1]};
                rx_cnt_d = bit_max;
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_state_d = RxStop;
            end
            RxStop: if (rx_tick) begin
                rx_state_d = RxIdle;
                rx_stop_ok = rx;
                rx_stop_bad = ~rx;
            end
            default: rx_state_d = RxIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (txf_push) txf_mem_q[txf_wp_q] <= dtw[7:0];
        if (rxf_push) rxf_mem_q[rxf_wp_q] <= rx_sh_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_q <= 1'b0;
            dtr_q <= '0;
            div_q <= '0;
            ctrl_q <= '0;
            ovr_q <= 1'b0;
            ferr_q <= 1'b0;
            int_rx_q <= 1'b0;
            int_tx_q <= 1'b0;
            txf_wp_q <= '0;
            txf_rp_q <= '0;
            txf_cnt_q <= '0;
            rxf_wp_q <= '0;
            rxf_rp_q <= '0;
            rxf_cnt_q <= '0;
            tx_state_q <= TxIdle;
            tx_cnt_q <= '0;
            tx_sh_q <= '0;
            tx_bit_q <= '0;
            tx_q <= 1'b1;
            rx_state_q <= RxIdle;
            rx_cnt_q <= '0;
            rx_sh_q <= '0;
            rx_bit_q <= '0;
        end else begin
            ack_q <= ack_d;
            dtr_q <= dtr_d;
            div_q <= div_d;
            ctrl_q <= ctrl_d;
            ovr_q <= ovr_d;
            ferr_q <= ferr_d;
            int_rx_q <= int_rx_d;
            int_tx_q <= int_tx_d;
            if (txf_push) txf_wp_q <= txf_wp_q + PtrOne;
            if (tx_pop) txf_rp_q <= txf_rp_q + PtrOne;
            txf_cnt_q <= txf_cnt_d;
            if (rxf_push) rxf_wp_q <= rxf_wp_q + PtrOne;
            if (rxf_pop) rxf_rp_q <= rxf_rp_q + PtrOne;
            rxf_cnt_q <= rxf_cnt_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q <= tx_cnt_d;
            tx_sh_q <= tx_sh_d;
            tx_bit_q <= tx_bit_d;
            tx_q <= tx_d;
            rx_state_q <= rx_state_d;
            rx_cnt_q <= rx_cnt_d;
            rx_sh_q <= rx_sh_d;
            rx_bit_q <= rx_bit_d;
        end
    end

    assign ack = ack_q;
    assign dtr = dtr_q;
    assign tx = tx_q;
    assign int_rx = int_rx_q;
    assign int_tx = int_tx_q;
endmodule

// File: tb/tb_dev_uart.sv
// Bench for dev_uart: random bytes and divisors checked against queue models of the FIFOs
// and a line monitor that decodes tx frames from the expected bit period.
`timescale 1ns/1ps
module tb_dev_uart;
    logic        clk = 1'b0, reset = 1'b1, stb = 1'b0, rw = 1'b0, rx_drv = 1'b1, loop_en = 1'b0;
    logic [9:0]  addr = '0;
    logic [31:0] dtw = '0;
    logic        ack, tx, int_rx, int_tx, rx;
    logic [31:0] dtr;

    assign rx = loop_en ? tx : rx_drv;

    dev_uart dut (
        .clk   (clk),
        .reset (reset),
        .stb   (stb),
        .ack   (ack),
        .addr  (addr),
        .rw    (rw),
        .dtw   (dtw),
        .dtr   (dtr),
        .rx    (rx),
        .tx    (tx),
        .int_rx(int_rx),
        .int_tx(int_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, failures = 0, last_lat = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Line monitor: a falling edge starts a frame; each bit is sampled mid-period.
    int         mon_p = 4;
    logic [7:0] mon_byte[$];
    logic       mon_stop[$];
    int         mon_start[$];
    int         mon_low[$];

    initial begin : tx_monitor
        logic       prev;
        logic [9:0] bits;
        int         s, low, p;
        bit         run;
        prev = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!reset && prev === 1'b1 && tx === 1'b0) begin
                s = cyc;
                p = mon_p;
                low = 0;
                run = 1'b1;
                bits = '0;
                for (int t = 0; t < 10 * p; t++) begin
                    if (t > 0) begin
                        @(posedge clk);
                        #2;
                    end
                    if (run && tx === 1'b0) low++;
                    else run = 1'b0;
                    if (t % p == p / 2) bits[t / p] = tx;
                end
                mon_byte.push_back(bits[8:1]);
                mon_stop.push_back(bits[9]);
                mon_start.push_back(s);
                mon_low.push_back(low);
            end
            prev = tx;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus(input logic w, input logic [9:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        int n = 0;
        stb = 1'b1;
        rw = w;
        addr = a;
        dtw = d;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ack !== 1'b1 && n < 8);
        last_lat = n;
        r = dtr;
        stb = 1'b0;
        rw = 1'b0;
        if (ack !== 1'b1) check_val("ack_timeout", 32'(n), 32'd1);
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus(1'b1, a, d, dummy);
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] r);
        bus(1'b0, a, 32'h0, r);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int p);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rx_drv = f[k];
            tick(p);
        end
        rx_drv = 1'b1;
        tick(3);
    endtask

    task automatic wait_frames(input int n, input int budget);
        int c = 0;
        while (mon_byte.size() < n && c < budget) begin
            tick(1);
            c++;
        end
        if (mon_byte.size() < n) check_val("frame_timeout", 32'(mon_byte.size()), 32'(n));
    endtask

    function automatic logic [31:0] status_exp(input int txn, input int rxn, input logic ovr,
                                               input logic ferr, input logic busy);
        logic [31:0] s = '0;
        s[0] = (txn == 8);
        s[1] = (txn == 0);
        s[2] = (rxn > 0);
        s[3] = (rxn == 8);
        s[4] = ovr;
        s[5] = ferr;
        s[6] = busy;
        s[11:8] = 4'(rxn);
        s[15:12] = 4'(txn);
        return s;
    endfunction

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] r;
        logic [7:0]  q_tx[$];
        logic [7:0]  q_rx[$];
        logic [7:0]  b;
        logic        ovr;
        int          d, p, c, t0, lows;

        // Reset state
        tick(3);
        check_val("rst_tx", 32'(tx), 32'd1);
        check_val("rst_ack", 32'(ack), 32'd0);
        check_val("rst_dtr", dtr, 32'd0);
        check_val("rst_int_rx", 32'(int_rx), 32'd0);
        check_val("rst_int_tx", 32'(int_tx), 32'd0);
        reset = 1'b0;
        tick(1);
        rd(10'd1, r);
        check_val("rst_status", r, 32'h2);
        check_val("ack_latency", 32'(last_lat), 32'd1);
        tick(1);
        check_val("ack_one_cycle", 32'(ack), 32'd0);
        check_val("dtr_idle_zero", dtr, 32'd0);
        rd(10'd2, r);
        check_val("rst_div", r, 32'd0);
        rd(10'd3, r);
        check_val("rst_ctrl", r, 32'd0);
        rd(10'd9, r);
        check_val("unmapped_read", r, 32'd0);

        // Loopback of 0xA5 with DIV=3
        loop_en = 1'b1;
        mon_p = 4;
        wr(10'd2, 32'd3);
        wr(10'd3, 32'h7);
        mon_byte.delete(); mon_stop.delete(); mon_start.delete(); mon_low.delete();
        wr(10'd0, 32'hA5);
        wait_frames(1, 200);
        if (mon_byte.size() > 0) begin
            check_val("lb_byte", 32'(mon_byte[0]), 32'hA5);
            check_val("lb_stop", 32'(mon_stop[0]), 32'd1);
            check_val("lb_start_len", 32'(mon_low[0]), 32'd4);
            t0 = mon_start[0];
            c = 0;
            while (int_rx !== 1'b1 && c < 60) begin
                tick(1);
                c++;
            end
            check_val("lb_int_rx", 32'(int_rx), 32'd1);
            check_val("lb_int_rx_after_stop", 32'(cyc - t0 >= 38 && cyc - t0 <= 46), 32'd1);
        end
        rd(10'd0, r);
        check_val("lb_read", r, 32'h1A5);
        rd(10'd0, r);
        check_val("lb_read_empty", r, 32'h0);
        tick(2);
        check_val("lb_int_rx_clear", 32'(int_rx), 32'd0);

        // Random bytes at random divisors through the loopback
        for (int i = 0; i < 6; i++) begin
            d = int'($urandom_range(0, 6));
            p = ((d < 3) ? 3 : d) + 1;
            mon_p = p;
            wr(10'd2, 32'(d));
            b = 8'($urandom);
            mon_byte.delete(); mon_stop.delete(); mon_start.delete(); mon_low.delete();
            wr(10'd0, 32'(b));
            wait_frames(1, 12 * p + 20);
            if (mon_byte.size() > 0) check_val("rand_tx_byte", 32'(mon_byte[0]), 32'(b));
            tick(4);
            rd(10'd0, r);
            check_val("rand_rx_read", r, {23'b0, 1'b1, b});
        end

        // TX fill with tx_en clear, then drain
        loop_en = 1'b0;
        rx_drv = 1'b1;
        wr(10'd3, 32'h0);
        wr(10'd2, 32'd3);
        mon_p = 4;
        mon_byte.delete(); mon_stop.delete(); mon_start.delete(); mon_low.delete();
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            wr(10'd0, 32'(b));
            if (q_tx.size() < 8) q_tx.push_back(b);
        end
        rd(10'd1, r);
        check_val("fill_status", r, status_exp(q_tx.size(), 0, 1'b0, 1'b0, 1'b0));
        check_val("fill_int_tx", 32'(int_tx), 32'd0);
        wr(10'd3, 32'h9);
        wait_frames(8, 8 * 40 + 100);
        if (mon_byte.size() >= 8) begin
            for (int i = 0; i < 8; i++) begin
                check_val("drain_byte", 32'(mon_byte[i]), 32'(q_tx[i]));
                if (i > 0) check_val("drain_spacing", 32'(mon_start[i] - mon_start[i-1]), 32'd40);
            end
        end
        tick(60);
        check_val("drain_frame_count", 32'(mon_byte.size()), 32'd8);
        check_val("drain_int_tx", 32'(int_tx), 32'd1);
        rd(10'd1, r);
        check_val("drain_status", r, status_exp(0, 0, 1'b0, 1'b0, 1'b0));

        // RX overrun
        wr(10'd3, 32'h2);
        wr(10'd2, 32'd4);
        ovr = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            send_frame(b, 1'b1, 5);
            if (q_rx.size() < 8) q_rx.push_back(b);
            else ovr = 1'b1;
        end
        tick(2);
        rd(10'd1, r);
        check_val("ovr_status", r, status_exp(0, q_rx.size(), ovr, 1'b0, 1'b0));
        wr(10'd1, 32'h10);
        rd(10'd1, r);
        check_val("ovr_w1c", r, status_exp(0, q_rx.size(), 1'b0, 1'b0, 1'b0));
        while (q_rx.size() > 0) begin
            rd(10'd0, r);
            check_val("ovr_byte", r, {23'b0, 1'b1, q_rx.pop_front()});
        end
        rd(10'd1, r);
        check_val("ovr_drained", r, status_exp(0, 0, 1'b0, 1'b0, 1'b0));

        // Framing error, glitch rejection, recovery
        send_frame(8'($urandom), 1'b0, 5);
        tick(2);
        rd(10'd1, r);
        check_val("ferr_status", r, status_exp(0, 0, 1'b0, 1'b1, 1'b0));
        rd(10'd0, r);
        check_val("ferr_no_push", r, 32'h0);
        wr(10'd1, 32'h20);
        rd(10'd1, r);
        check_val("ferr_w1c", r, status_exp(0, 0, 1'b0, 1'b0, 1'b0));
        wr(10'd2, 32'd7);
        rx_drv = 1'b0;
        tick(1);
        rx_drv = 1'b1;
        tick(40);
        rd(10'd1, r);
        check_val("glitch_status", r, status_exp(0, 0, 1'b0, 1'b0, 1'b0));
        b = 8'($urandom);
        send_frame(b, 1'b1, 8);
        rd(10'd0, r);
        check_val("post_glitch_rx", r, {23'b0, 1'b1, b});

        // Reset during a frame in DATA
        wr(10'd2, 32'd3);
        wr(10'd3, 32'h1);
        wr(10'd0, 32'h00);
        wr(10'd0, 32'h5A);
        c = 0;
        while (tx !== 1'b0 && c < 50) begin
            tick(1);
            c++;
        end
        tick(10);
        check_val("mid_frame_tx_low", 32'(tx), 32'd0);
        reset = 1'b1;
        tick(1);
        check_val("reset_tx_high", 32'(tx), 32'd1);
        tick(1);
        reset = 1'b0;
        tick(1);
        rd(10'd1, r);
        check_val("reset_fifos_empty", r, status_exp(0, 0, 1'b0, 1'b0, 1'b0));
        lows = 0;
        repeat (200) begin
            tick(1);
            if (tx !== 1'b1) lows++;
        end
        check_val("reset_no_frame", 32'(lows), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dev_uart.md
Name: dev_uart

Overview:
- Memory-mapped 8N1 UART peripheral that occupies one device slot on the MMIO interconnect, alongside the timers and the general config table.
- Consumes the interconnect's per-device strobe, shared 10-bit word address, write data and rw; returns read data and ack.
- TX and RX each have a FIFO; the baud divisor is programmable.
- The RX input comes from the synchronised output of the existing GPIO input filter. Level interrupt outputs feed the AIC interrupt vector.

Parameters:
- FIFO_AW, 3, log2 of TX and RX FIFO depth (depth 8).
- DIV_BITS, 16, width of the baud divisor register.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stb  in  1  device select from interconnect, held until ack
- ack  out  1  one-cycle transaction acknowledge
- addr  in  10  word address within device
- rw  in  1  1=write, 0=read
- dtw  in  32  write data
- dtr  out  32  read data, valid while ack=1
- rx  in  1  serial input, already synchronised, idle high
- tx  out  1  serial output, idle high
- int_rx  out  1  RX data-available interrupt (level)
- int_tx  out  1  TX drained interrupt (level)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high, using the codebase names clk and reset. Reset takes effect on the next clk edge regardless of bus or line state.
- Reset values: ack=0, dtr=0, tx=1, int_rx=0, int_tx=0. Both FIFOs empty, DIV=0, CTRL=0, OVR=0, FERR=0. TX and RX state machines return to IDLE. A frame in flight is aborted and tx goes high immediately.
- Bus handshake:
  - ack=1 in the cycle after stb is sampled with ack=0. ack lasts one cycle, then ack=0 for at least one cycle.
  - Side effects (push, pop, register write) happen exactly once per transaction, on the cycle stb is sampled.
  - dtr is registered and is 0 when ack=0.
- Register map (addr):
  - 0 DATA.
    - Write pushes dtw[7:0] to the TX FIFO. If the FIFO is full, the data is dropped and the write is still acked.
    - Read returns {23'b0, valid, byte}. If the RX FIFO is non-empty, valid=1, byte is the head entry, and the entry is popped. If empty, the read returns 0 and nothing is popped.
  - 1 STATUS, read-only except W1C bits.
    - Bit fields: [0] tx_full, [1] tx_empty, [2] rx_avail, [3] rx_full, [4] OVR (W1C), [5] FERR (W1C), [6] tx_busy, [11:8] rx_count, [15:12] tx_count, all other bits 0.
  - 2 DIV: read/write, DIV_BITS wide, zero-extended on read.
    - Bit period = max(DIV,3)+1 clocks.
  - 3 CTRL: [0] tx_en, [1] rx_en, [2] rx_ie, [3] tx_ie.
  - Other addresses: reads return 0, writes are ignored, ack is still given.
- TX state machine (IDLE, START, DATA, STOP):
  - IDLE → START when tx_en=1 and the TX FIFO is non-empty. The FIFO is popped on that transition.
  - Each state lasts one bit period: START drives 0; DATA drives bits 0..7, LSB first; STOP drives 1.
  - After STOP: → START back-to-back if tx_en=1 and the FIFO is non-empty, otherwise → IDLE.
  - tx_busy=1 whenever the state is not IDLE.
  - Clearing tx_en mid-frame finishes the current frame.
- RX state machine (IDLE, START, DATA, STOP):
  - IDLE → START on rx=0 while rx_en=1.
  - START: wait half a bit period, (P)>>1 clocks where P is the bit period. If rx=1 there, return to IDLE as a glitch; otherwise → DATA.
  - DATA: sample 8 bits at full bit-period spacing, LSB first.
  - STOP: sample one bit period later, then return to IDLE.
    - If stop=1 and the FIFO is not full: push the byte.
    - If stop=1 and the FIFO is full: drop the byte and set OVR.
    - If stop=0: drop the byte and set FERR.
  - Clearing rx_en mid-frame finishes the current frame.
- Simultaneous events:
  - Bus pop and RX push in the same cycle on a full FIFO: the pop is processed first, so the push succeeds with no OVR.
  - TX pop and bus push in the same cycle on a full FIFO: the push succeeds.
  - A W1C write and a set event in the same cycle: the set wins.
- Counts and FIFOs:
  - Counts are FIFO_AW+1 bits, reported in a 4-bit field.
  - FIFO pointers wrap modulo depth.
- Interrupts:
  - int_rx = rx_ie & rx_avail.
  - int_tx = tx_ie & tx_empty & ~tx_busy.
  - Both are registered, one cycle of latency after the condition.
- The DIV write takes effect at the next bit boundary of the current frame.

Test Plan:
- Reset → tx=1, STATUS read returns 0x0002, DIV/CTRL read 0, int_rx=int_tx=0.
- Loopback (tx tied to rx): DIV=3, CTRL=0x7, write DATA=0xA5.
  - tx low 4 clocks at frame start; frame lasts 40 clocks.
  - int_rx rises after the stop bit; DATA read returns 0x1A5; a second read returns 0x000.
- Fill TX with 9 writes while tx_en=0 → tx_count=8 and tx_full=1; 9th byte dropped.
  - Set tx_en: exactly 8 back-to-back frames, then int_tx=1 (tx_ie set).
- Overrun: receive 9 bytes without reading → rx_count=8, OVR=1, first 8 bytes intact.
  - Writing STATUS=0x10 clears OVR.
- Framing error and glitch:
  - Drive a frame with stop bit 0 → FERR=1, no push.
  - A 1-clock low pulse on rx with DIV=7 → no frame, STATUS unchanged.
- Reset asserted mid-frame (TX in DATA) → tx=1 next cycle, FIFOs empty, no further frame is transmitted.
